bitstream_byte_fifo: RTL and testbench

Byte prefetch buffer upstream of the arithmetic `Decoder`. It accepts bitstream bytes from the source side over a valid/ready handshake and serves the decoder's `request_byte` pulses. The head byte is held stable on `data` until it is consumed. It replaces the simulation-only `FileReader` in synthesizable builds and decouples source stalls from decoder renormalisation.

---
 rtl/bitstream_byte_fifo.sv | 93 +++++++++
 tb/tb_bitstream_byte_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_byte_fifo.sv
// Byte prefetch buffer feeding the arithmetic decoder: circular storage
// followed by a registered head byte that is held until the decoder consumes it.
module bitstream_byte_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              request,
    output logic [7:0]        data,
    output logic              data_ready,
    output logic [ADDR_W:0]   level,
    output logic              underflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              wr_en;
    logic              consume;
    logic              refill;
    logic [CNT_W-1:0]  count_nxt;
    logic              data_ready_nxt;

    // Handshake decode and next occupancy; in_ready is a register so the
    // source never sees a combinational path from request or in_valid.
    always_comb begin
        wr_en          = in_valid & in_ready;
        consume        = request & data_ready;
        refill         = (~data_ready | consume) & (count != '0);
        count_nxt      = count + CNT_W'(wr_en) - CNT_W'(refill);
        data_ready_nxt = data_ready;
        if (refill) begin
            data_ready_nxt = 1'b1;
        end else if (consume) begin
            data_ready_nxt = 1'b0;
        end
    end

    // Storage array; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy, head register and status flags; flush wins over
    // any concurrent write or request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data       <= 8'h00;
            data_ready <= 1'b0;
            in_ready   <= 1'b1;
            level      <= '0;
            underflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data       <= 8'h00;
            data_ready <= 1'b0;
            in_ready   <= 1'b1;
            level      <= '0;
            underflow  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (refill) begin
                data   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count      <= count_nxt;
            data_ready <= data_ready_nxt;
            in_ready   <= (count_nxt != FULL_CNT);
            level      <= count_nxt + CNT_W'(data_ready_nxt);
            underflow  <= underflow | (request & ~data_ready);
        end
    end

endmodule

// File: tb/tb_bitstream_byte_fifo.sv
// Directed self-checking bench for bitstream_byte_fifo (DEPTH=16).
module tb_bitstream_byte_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       request = 1'b0;
    logic [7:0] data;
    logic       data_ready;
    logic [4:0] level;
    logic       underflow;

    int n_vec = 0;
    int n_err = 0;

    bitstream_byte_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .request    (request),
        .data       (data),
        .data_ready (data_ready),
        .level      (level),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one edge, then settle before sampling or driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_data"}, 32'(data), 32'h00);
        check({tag, "_dr"}, 32'(data_ready), 32'd0);
        check({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_uflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        int wr_idx;
        int rd_idx;
        int cyc;
        int accepted;
        logic fire;

        // reset held for 3 cycles
        repeat (3) tick();
        check_idle("rst");
        reset = 1'b1;

        // fill 0x11, 0x22, 0x33 with no requests
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        check("fill1_dr", 32'(data_ready), 32'd0);
        check("fill1_level", 32'(level), 32'd1);
        in_data = 8'h22;
        tick();
        check("fill2_data", 32'(data), 32'h11);
        check("fill2_dr", 32'(data_ready), 32'd1);
        in_data = 8'h33;
        tick();
        check("fill3_level", 32'(level), 32'd3);
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fill_flush_level", 32'(level), 32'd0);

        // streaming 0x00..0x13 across pointer wrap
        wr_idx = 0; rd_idx = 0; cyc = 0;
        while (rd_idx < 20 && cyc < 100) begin
            in_valid = (wr_idx < 20);
            in_data  = 8'(wr_idx);
            request  = data_ready;
            if (data_ready) begin
                check("stream_data", 32'(data), 32'(rd_idx));
                rd_idx++;
            end
            fire = in_valid & in_ready;
            tick();
            cyc++;
            if (fire) wr_idx++;
        end
        in_valid = 1'b0; request = 1'b0;
        check("stream_count", 32'(rd_idx), 32'd20);
        check("stream_cycles", 32'(cyc), 32'd22);
        check("stream_end_level", 32'(level), 32'd0);
        check("stream_end_dr", 32'(data_ready), 32'd0);

        // full and backpressure
        accepted = 0; cyc = 0;
        in_valid = 1'b1;
        while (cyc < 40) begin
            in_data = 8'(8'h80 + accepted);
            if (!in_ready) break;
            tick();
            accepted++;
            cyc++;
        end
        check("full_accepted", 32'(accepted), 32'd17);
        check("full_level", 32'(level), 32'd17);
        repeat (2) tick();
        check("full_hold_inrdy", 32'(in_ready), 32'd0);
        check("full_hold_level", 32'(level), 32'd17);
        check("full_head", 32'(data), 32'h80);
        request = 1'b1;
        tick();
        request = 1'b0;
        check("bp_pop_inrdy", 32'(in_ready), 32'd1);
        check("bp_pop_level", 32'(level), 32'd16);
        check("bp_pop_data", 32'(data), 32'h81);
        tick();
        in_valid = 1'b0;
        check("bp_refill_level", 32'(level), 32'd17);
        check("bp_refill_inrdy", 32'(in_ready), 32'd0);
        request = 1'b1;
        for (int i = 0; i < 17; i++) begin
            check("bp_drain_data", 32'(data), 32'(8'h81 + i));
            tick();
        end
        request = 1'b0;
        check("bp_drain_level", 32'(level), 32'd0);

        // underflow from empty
        request = 1'b1;
        tick();
        request = 1'b0;
        check("uf_flag", 32'(underflow), 32'd1);
        check("uf_dr", 32'(data_ready), 32'd0);
        check("uf_level", 32'(level), 32'd0);
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        check("uf_wr_dr", 32'(data_ready), 32'd0);
        tick();
        check("uf_data", 32'(data), 32'h5A);
        check("uf_dr2", 32'(data_ready), 32'd1);
        check("uf_sticky", 32'(underflow), 32'd1);
        request = 1'b1;
        tick();
        request = 1'b0;
        check("uf_drain_level", 32'(level), 32'd0);

        // flush against a simultaneous write and request
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'h40 + i);
            tick();
        end
        in_valid = 1'b0;
        check("fl_pre_level", 32'(level), 32'd5);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; request = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; request = 1'b0;
        check_idle("fl");
        repeat (2) tick();
        check("fl_no77_level", 32'(level), 32'd0);
        check("fl_no77_dr", 32'(data_ready), 32'd0);

        // asynchronous reset mid-stream
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'(8'hA0 + i);
            tick();
        end
        in_valid = 1'b0;
        check("mr_pre_level", 32'(level), 32'd9);
        #2 reset = 1'b0;
        #1;
        check_idle("mr");
        tick();
        reset = 1'b1;
        check_idle("mr_hold");
        in_valid = 1'b1; in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        check("mr_wr_dr", 32'(data_ready), 32'd0);
        tick();
        check("mr_data", 32'(data), 32'hC3);
        check("mr_dr", 32'(data_ready), 32'd1);
        check("mr_level", 32'(level), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
